// File: rtl/sum_seq_pkg.sv
// rtl/sum_seq_pkg.sv - shared types and sizing helpers for the chunked adder/subtractor
package sum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk build still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_chunk.sv
// rtl/sum_chunk.sv - combinational CHUNK-bit ripple adder, exposes carry into its top bit
module sum_chunk #(
    parameter int CHUNK = 4
) (
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin
);

    always_comb begin : ripple
        logic [CHUNK:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout     = c[CHUNK];
        c_msb_in = c[CHUNK - 1];
    end

endmodule

// File: rtl/sum_seq.sv
// rtl/sum_seq.sv - multi-cycle WIDTH-bit adder/subtractor, one CHUNK per clock, LSB first
module sum_seq
    import sum_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    logic             last;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                a_chunk = a_reg[k*CHUNK +: CHUNK];
                b_chunk = b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    assign last = (idx == IW'(NCHUNK - 1));

    sum_chunk #(.CHUNK(CHUNK)) u_chunk (
        .sum      (chunk_sum),
        .cout     (chunk_cout),
        .c_msb_in (chunk_c_msb),
        .a        (a_chunk),
        .b        (b_chunk),
        .cin      (carry)
    );

    // Subtraction is a + ~b + ~borrow, so B and the carry are pre-inverted at load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub}};
                        carry <= sub ^ cin;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k)) begin
                            sum[k*CHUNK +: CHUNK] <= chunk_sum;
                        end
                    end
                    carry <= chunk_cout;
                    idx   <= idx + IW'(1);
                    if (last) begin
                        cout  <= chunk_cout;
                        ovf   <= chunk_c_msb ^ chunk_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_seq.sv
// tb/tb_sum_seq.sv - table-driven, scoreboarded bench for sum_seq at WIDTH=16, CHUNK=4
module tb_sum_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    sum_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   cnt = 0;
    int   errs = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;
    logic last_c = 1'b0;
    logic last_o = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        cnt++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Arithmetic reference: integer add/subtract, signed range test for overflow.
    function automatic exp_t model(input logic s, input logic [15:0] av, input logic [15:0] bv,
                                   input logic ci);
        exp_t m;
        int ua, ub, sa, sb, r, sr;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (!s) begin
            r   = ua + ub + int'(ci);
            sr  = sa + sb + int'(ci);
            m.c = (r > 65535);
        end else begin
            r   = ua - ub - int'(ci);
            sr  = sa - sb - int'(ci);
            m.c = (r >= 0);
        end
        m.s = r[15:0];
        m.o = (sr > 32767) || (sr < -32768);
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
                chk("busy_cycles", busy_cnt, 32'd4);
                busy_cnt = 0;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", {16'd0, sum}, {16'd0, e.s});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                end
            end
            prev_done = done;
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE; returns just after the start edge.
    task automatic launch(input logic s, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input exp_t e);
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        cin   = ci;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("sum_cleared", {16'd0, sum}, 32'd0);
        chk("cout_held", {31'd0, cout}, {31'd0, last_c});
        chk("ovf_held", {31'd0, ovf}, {31'd0, last_o});
    endtask

    task automatic wait_done(output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int   lat;
        exp_t e;
        exp_t e2;

        vecs[0] = '{1'b0, 16'h0001, 16'hFFFD, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 16'h000C, 1'b0, 16'hFFF9, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 16'h0010, 16'h0005, 1'b1, 16'h000A, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            e.s = vecs[i].es;
            e.c = vecs[i].ec;
            e.o = vecs[i].eo;
            launch(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ci, e);
            wait_done(lat);
            chk("latency", lat, 32'd5);
            last_c = e.c;
            last_o = e.o;
            @(negedge clk);
            chk("idle_after_done", {30'd0, busy, done}, 32'd0);
            chk("sum_hold", {16'd0, sum}, {16'd0, e.s});
        end

        for (int i = 0; i < 4; i++) begin
            logic        rs, rc;
            logic [15:0] ra, rb;
            rs = 1'($urandom_range(1));
            rc = 1'($urandom_range(1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            e  = model(rs, ra, rb, rc);
            launch(rs, ra, rb, rc, e);
            wait_done(lat);
            chk("rand_latency", lat, 32'd5);
            last_c = e.c;
            last_o = e.o;
            @(negedge clk);
        end

        // Start raised mid-BUSY must be ignored, then held into DONE to chain the next op.
        e  = model(1'b1, 16'h8000, 16'h0001, 1'b0);
        launch(1'b1, 16'h8000, 16'h0001, 1'b0, e);
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        e2.s  = 16'h3333;
        e2.c  = 1'b0;
        e2.o  = 1'b0;
        q.push_back(e2);
        wait_done(lat);
        chk("b2b_first_latency", lat, 32'd4);
        last_c = e.c;
        last_o = e.o;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
        chk("b2b_no_idle_done", {31'd0, done}, 32'd0);
        chk("b2b_sum_cleared", {16'd0, sum}, 32'd0);
        chk("b2b_cout_held", {31'd0, cout}, {31'd0, last_c});
        chk("b2b_ovf_held", {31'd0, ovf}, {31'd0, last_o});
        wait_done(lat);
        chk("b2b_second_latency", lat, 32'd5);
        last_c = e2.c;
        last_o = e2.o;
        @(negedge clk);

        // Asynchronous reset in the second BUSY cycle discards the operation.
        e = model(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        launch(1'b0, 16'hFFFF, 16'h0001, 1'b0, e);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        last_c = 1'b0;
        last_o = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
        e = model(1'b0, 16'h0102, 16'h0304, 1'b1);
        launch(1'b0, 16'h0102, 16'h0304, 1'b1, e);
        wait_done(lat);
        chk("post_rst_latency", lat, 32'd5);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sum_seq.md
# sum_seq

Parametrised multi-cycle adder/subtractor that generalises the 4-bit ripple adder to WIDTH bits. Operands are processed CHUNK bits per clock, LSB chunk first, through one shared chunk adder, and the carry is registered between chunks. A start/busy/done handshake connects the block to the datapath controller. Signed overflow and carry/borrow flags are produced alongside the result.

## Interface
- `WIDTH`, default 16: operand and result width; must be a multiple of CHUNK.
- `CHUNK`, default 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request a new operation; sampled only in IDLE or DONE.
- `sub`  in  1: 0 computes a+b+cin; 1 computes a−b−cin.
- `a`  in  WIDTH: operand A, sampled with start.
- `b`  in  WIDTH: operand B, sampled with start.
- `cin`  in  1: carry-in (add) or borrow-in (sub), sampled with start.
- `busy`  out  1: high while chunks are being processed.
- `done`  out  1: one-cycle pulse; results valid this cycle.
- `sum`  out  WIDTH: result.
- `cout`  out  1: raw carry out of MSB; for sub, 1 means no borrow.
- `ovf`  out  1: two's-complement overflow.

## Operation
- Define NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE: waiting for start.
  - BUSY: processing chunks.
  - DONE: results presented for one cycle.
- IDLE → BUSY on start=1. The start edge loads:
  - `a` into the A register.
  - `b ^ {WIDTH{sub}}` into the B register.
  - `sub ^ cin` into the carry register.
  - 0 into the chunk index and the sum register.
- BUSY, each edge:
  - Chunk idx of A, chunk idx of B and the carry go into the chunk adder.
  - Chunk sum is written to sum bits [idx*CHUNK +: CHUNK].
  - Carry register takes the chunk carry-out.
  - idx increments.
- On the edge that processes idx = NCHUNK−1:
  - `cout` takes the final carry.
  - `ovf` takes carry-into-MSB XOR carry-out-of-MSB, captured from the last chunk.
  - State → DONE.
- DONE → IDLE after one cycle. If start=1 in DONE, the new operation loads and the state goes directly to BUSY.
- start in BUSY is ignored; operands may change freely.
- sum, cout and ovf hold their values until the next operation's start edge. At that edge the sum register clears; cout and ovf keep the previous values until the final-chunk edge.
- Wrap-around: the result is modulo 2^WIDTH; the carry shows only on cout.

## Timing
- Reset (rst_n=0, any time, including mid-BUSY):
  - State = IDLE, idx = 0.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Any in-flight operation is discarded.
- Start sampled at edge E0:
  - busy = 1 from after E0 through edge E_NCHUNK (exactly NCHUNK cycles).
  - done = 1 and busy = 0 in the cycle after E_NCHUNK.
- Latency from start edge to done is NCHUNK+1 edges.
- Back-to-back throughput is one result per NCHUNK+1 cycles.
- busy and done are registered and never high together.
- Degenerate case WIDTH=CHUNK: NCHUNK=1, so busy lasts one cycle and done follows.

## Structure
- Package `sum_seq_pkg` holds:
  - The state enumeration IDLE/BUSY/DONE.
  - A helper function for NCHUNK.
  - The index-width calculation ($clog2(NCHUNK), minimum 1).
- Sub-module `sum_chunk` is a combinational CHUNK-bit ripple adder.
  - Ports: sum, cout, c_msb_in, a, b, cin.
  - c_msb_in is the carry into the top bit, used for ovf.
  - One instance, shared across cycles.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Add, no carry: a=0x0001, b=0xFFFD, cin=0, sub=0 → after 5 edges sum=0xFFFE, cout=0, ovf=0; busy high exactly 4 cycles; done pulses 1 cycle.
- Signed overflow: a=0x7FFF, b=0x0001, add → sum=0x8000, cout=0, ovf=1.
- Full carry chain: a=0xFFFF, b=0xFFFF, cin=1, add → sum=0xFFFF, cout=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x000C, sub=1, cin=0 → sum=0xFFF9, cout=0, ovf=0.
- Subtract, overflow, back-to-back: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1. Then:
  - start during BUSY is ignored.
  - start held in DONE launches the next op immediately, with no IDLE cycle.
- Reset mid-operation: rst_n low at cycle 2 of BUSY → all outputs 0 asynchronously. After release, a fresh start yields a correct result with no residue from the aborted op.
